// File: rtl/rptr_empty.sv
// Read-side pointer and empty-flag controller for the dual-clock FIFO (rclk domain).
// RPTR_EMPTY_STATUS_EN adds the rcount fill level and the almost-empty compare.
module rptr_empty #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rinc,
    input  logic                rclr_err,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                runderflow
);

    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic              rempty_q, rempty_d;
    logic              runderflow_q, runderflow_d;
    logic              rd_ok;

    always_comb begin
        rd_ok        = rinc & ~rempty_q;
        rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, rd_ok};
        rptr_d       = (rbin_d >> 1) ^ rbin_d;
        // Full-width Gray compare so the wrap bit separates empty from full
        rempty_d     = (rptr_d == rq2_wptr);
        runderflow_d = runderflow_q;
        if (rinc & rempty_q)
            runderflow_d = 1'b1;
        else if (rclr_err)
            runderflow_d = 1'b0;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rempty_q     <= rempty_d;
            runderflow_q <= runderflow_d;
        end
    end

`ifdef RPTR_EMPTY_STATUS_EN
    localparam logic [ADDRSIZE:0] AE_TH = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] rcount_q, rcount_d;
    logic              raempty_q, raempty_d;

    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++)
            wbin_s[i] = ^(rq2_wptr >> i);
        rcount_d  = wbin_s - rbin_d;
        raempty_d = (rcount_d <= AE_TH);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rcount_q  <= '0;
            raempty_q <= 1'b1;
        end else begin
            rcount_q  <= rcount_d;
            raempty_q <= raempty_d;
        end
    end

    assign rcount  = rcount_q;
    assign raempty = raempty_q;
`else
    assign rcount  = '0;
    assign raempty = rempty_q;
`endif

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Randomized bench for rptr_empty against an occupancy-counting reference model.
// Honors RPTR_EMPTY_STATUS_EN to pick the expected rcount/raempty behaviour.
module tb_rptr_empty;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;
    localparam int THR   = 2;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic [AW:0]   rq2_wptr;
    logic          rinc;
    logic          rclr_err;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
    logic          runderflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: total words written / read, plus expected flags
    int rd_total, wr_total;
    int m_rd, m_occ;
    bit m_empty, m_uf;

    rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(THR)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rinc(rinc),
        .rclr_err(rclr_err), .raddr(raddr), .rptr(rptr), .rempty(rempty),
        .raempty(raempty), .rcount(rcount), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return (b % PMOD) ^ ((b % PMOD) / 2);
    endfunction

    function automatic int from_gray(input int g);
        int b = 0;
        int acc = 0;
        for (int i = AW; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            b = b * 2 + acc;
        end
        return b;
    endfunction

    task automatic model_reset();
        rd_total = 0;
        m_rd = 0; m_occ = 0; m_empty = 1; m_uf = 0;
    endtask

    // advance the model by one rclk edge using the currently driven inputs
    task automatic model_step();
        bit was_empty;
        was_empty = m_empty;
        if (rinc && !was_empty) rd_total++;
        m_rd    = rd_total % PMOD;
        m_occ   = (from_gray(int'(rq2_wptr)) - m_rd + PMOD) % PMOD;
        m_empty = (m_occ == 0);
        if (rinc && was_empty) m_uf = 1;
        else if (rclr_err)     m_uf = 0;
    endtask

    task automatic check_all(input string where);
        int e_cnt, e_ae;
`ifdef RPTR_EMPTY_STATUS_EN
        e_cnt = m_occ;
        e_ae  = (m_occ <= THR);
`else
        e_cnt = 0;
        e_ae  = m_empty;
`endif
        check_eq({where, ".rptr"},       int'(rptr),       to_gray(m_rd));
        check_eq({where, ".raddr"},      int'(raddr),      m_rd % DEPTH);
        check_eq({where, ".rempty"},     int'(rempty),     int'(m_empty));
        check_eq({where, ".raempty"},    int'(raempty),    e_ae);
        check_eq({where, ".rcount"},     int'(rcount),     e_cnt);
        check_eq({where, ".runderflow"}, int'(runderflow), int'(m_uf));
    endtask

    initial begin
        int wprob;
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rclr_err = 1'b0;
        wr_total = 4;
        rq2_wptr = 5'b00110;
        model_reset();
        #12;
        check_all("reset");
        @(negedge rclk);
        rrst_n = 1'b1;
        model_step();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge rclk);
            check_all("run");
            if (cyc == 1500) begin
                rinc = 1'b0; rclr_err = 1'b0;
                #2 rrst_n = 1'b0;
                wr_total = 3;
                rq2_wptr = 5'(to_gray(3));
                model_reset();
                #1 check_all("async_rst");
                @(negedge rclk);
                check_all("rst_held");
                rrst_n = 1'b1;
                model_step();
                continue;
            end
            // alternate fast-write and slow-write epochs to visit both full and empty
            wprob    = ((cyc / 150) % 2 == 0) ? 70 : 25;
            rinc     = ($urandom_range(0, 99) < 55);
            rclr_err = ($urandom_range(0, 15) == 0);
            if ((wr_total - rd_total) < DEPTH && $urandom_range(0, 99) < wprob)
                wr_total++;
            rq2_wptr = 5'(to_gray(wr_total));
            model_step();
        end

        @(negedge rclk);
        check_all("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
